// File: rtl/smg_pkg.sv
// Shared constants and state encoding for the seven-segment BCD encoder.
// The sizing constants are defaults that the top module and the interface take as parameters.
package smg_pkg;

    localparam int DEFAULT_BIN_W   = 20;
    localparam int DEFAULT_DIGITS  = 6;
    localparam int DEFAULT_MAX_VAL = 999999;
    localparam int BCD_W           = 4 * DEFAULT_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/smg_bcd_encode_module_if.sv
// Request/result bundle between the binary producers and the BCD encoder.
// The producer side drives start_sig and bin_data; the encoder drives every other signal.
interface smg_bcd_encode_module_if #(
    parameter int BIN_W = smg_pkg::DEFAULT_BIN_W,
    parameter int NUM_W = smg_pkg::BCD_W
);

    logic             start_sig;
    logic [BIN_W-1:0] bin_data;
    logic             busy_sig;
    logic             done_sig;
    logic             ovf_sig;
    logic [NUM_W-1:0] number_sig;

    modport master (
        output start_sig, bin_data,
        input  busy_sig, done_sig, ovf_sig, number_sig
    );

    modport slave (
        input  start_sig, bin_data,
        output busy_sig, done_sig, ovf_sig, number_sig
    );

endinterface

// File: rtl/smg_bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added,
// so the next left shift carries into the following decimal digit.
module smg_bcd_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/smg_bcd_encode_module.sv
// Sequential binary-to-packed-BCD converter that shifts one bit per clock (double dabble).
// The display bus holds the previous result until the next conversion completes.
module smg_bcd_encode_module #(
    parameter int BIN_W   = smg_pkg::DEFAULT_BIN_W,
    parameter int DIGITS  = smg_pkg::DEFAULT_DIGITS,
    parameter int MAX_VAL = smg_pkg::DEFAULT_MAX_VAL
) (
    input  logic                     CLK,
    input  logic                     RST,
    smg_bcd_encode_module_if.slave   bus
);

    import smg_pkg::*;

    localparam int CNT_W   = $clog2(BIN_W + 1);
    localparam int BCD_LEN = 4 * DIGITS;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [BCD_LEN-1:0]   bcd_reg;
    logic [BCD_LEN-1:0]   bcd_adj;
    logic [BIN_W-1:0]     bin_reg;
    logic                 ovf_flag;
    logic                 ovf_reg;
    logic                 done_reg;
    logic [BCD_LEN-1:0]   number_reg;
    logic                 last_iter;
    logic                 over_max;

    assign last_iter = (cnt == CNT_W'(BIN_W - 1));
    assign over_max  = (bus.bin_data > BIN_W'(MAX_VAL));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        smg_bcd_add3 u_add3 (
            .nib_in  (bcd_reg[4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_sig) state_next = SHIFT;
            SHIFT:   if (last_iter)     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Oversized inputs are replaced by MAX_VAL at capture, so digit 5 can never carry out.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            bcd_reg    <= '0;
            bin_reg    <= '0;
            ovf_flag   <= 1'b0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
            number_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_sig) begin
                        bin_reg  <= over_max ? BIN_W'(MAX_VAL) : bus.bin_data;
                        bcd_reg  <= '0;
                        cnt      <= '0;
                        ovf_flag <= over_max;
                    end
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= {bcd_adj[BCD_LEN-2:0], bin_reg, 1'b0};
                    cnt                <= cnt + 1'b1;
                end
                DONE: begin
                    number_reg <= bcd_reg;
                    ovf_reg    <= ovf_flag;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_sig   = (state != IDLE);
    assign bus.done_sig   = done_reg;
    assign bus.ovf_sig    = ovf_reg;
    assign bus.number_sig = number_reg;

endmodule

// File: doc/smg_bcd_encode_module.md
Name: smg_bcd_encode_module

Overview:
Sequential binary-to-BCD converter that produces the 24-bit, 6-digit packed-BCD `number_sig` bus consumed by the seven-segment digit scanner. It uses shift-add-3 (double dabble), one bit per clock.
- Upstream logic (counters, EEPROM readback) issues a start pulse with a binary value.
- The block returns the BCD result with a done pulse.
- `number_sig` holds its last result steady between conversions, so the scanned display never flickers.

Parameters:
- BIN_W, 20, width of binary input; must satisfy 2^BIN_W > MAX_VAL.
- DIGITS, 6, number of BCD digits; `number_sig` width = 4*DIGITS.
- MAX_VAL, 999999, largest displayable value; inputs above it saturate.

Ports:
- CLK  in  1  system clock (50 MHz on board).
- RST  in  1  asynchronous reset, active-high.
- start_sig  in  1  conversion request; sampled only in IDLE.
- bin_data  in  BIN_W  binary value; captured on the edge start_sig is accepted.
- busy_sig  out  1  high from the accept edge until the return to IDLE.
- done_sig  out  1  one-cycle pulse; result valid.
- ovf_sig  out  1  registered with number_sig; 1 = last input exceeded MAX_VAL.
- number_sig  out  4*DIGITS  packed BCD, digit 5 (most significant) in [23:20], digit 0 in [3:0].

Behaviour:
- Reset (async, RST=1): state=IDLE, iteration counter=0, shift register=0, busy_sig=0, done_sig=0, ovf_sig=0, number_sig=24'h000000. Asserting RST mid-conversion abandons it; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE, start_sig=1 at edge E0:
  - capture bin_data; go to SHIFT; busy_sig=1; counter=0.
  - compare against MAX_VAL at capture; if greater, set internal ovf flag and load MAX_VAL instead of the input.
- IDLE, start_sig=0: hold all state.
- SHIFT, one iteration per edge:
  - every BCD nibble >= 5 gets +3 (combinational);
  - then the whole {bcd, bin} register shifts left by 1;
  - counter increments.
  - After BIN_W iterations (edges E1..E20), go to DONE.
- DONE, edge E21:
  - number_sig <= BCD register; ovf_sig <= ovf flag.
  - done_sig=1 for exactly this one cycle; busy_sig=0; state=IDLE.
- Latency: result and done_sig visible 21 cycles after the accept edge.
- start_sig while busy (SHIFT or DONE) is ignored; it is not queued.
- A start_sig high in the cycle after done_sig is accepted normally, giving a back-to-back throughput of 22 cycles per conversion.
- number_sig and ovf_sig change only at DONE; they are otherwise stable, including throughout a conversion.
- Nibble adjust never produces a nibble >9 after the shift for inputs <= MAX_VAL. Carry out of digit 5 is impossible given saturation.
- The iteration counter is $clog2(BIN_W+1) bits wide; it never wraps.

Decomposition:
- Package smg_pkg holds:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - DIGITS, BIN_W, MAX_VAL defaults;
  - BCD_W = 4*DIGITS.
- Sub-module smg_bcd_add3: combinational 4-bit nibble adjust (out = in>=5 ? in+3 : in), instantiated DIGITS times via generate.
- Everything else (FSM, counter, shift register, output registers) lives in the top module.

Test Plan:
- Reset then idle 10 cycles -> number_sig=24'h000000, busy_sig=0, done_sig=0, ovf_sig=0.
- start_sig pulse with bin_data=123456 -> busy_sig high for 21 cycles; done_sig high on cycle 21 only; number_sig=24'h123456; ovf_sig=0.
- Directed conversions of 0, 9, 10, 99999 and 999999 -> number_sig = 24'h000000, 24'h000009, 24'h000010, 24'h099999, 24'h999999 respectively.
- bin_data=1000000, then bin_data=20'hFFFFF -> number_sig=24'h999999 with ovf_sig=1 each time; a following conversion of 42 -> 24'h000042 with ovf_sig=0.
- Convert 555, then pulse start_sig with 777 at cycles 5 and 20 of the conversion -> 777 is ignored; only one done pulse; number_sig=24'h000555 and unchanged before done. A start with 777 in the cycle after done -> 24'h000777 exactly 21 cycles later.
- Start 314159 and assert RST at cycle 10 of the conversion -> all outputs 0 immediately; no done pulse. After release, converting 271828 -> 24'h271828.
